// File: rtl/soc_membus_arbiter.sv
// Shares one memory-bus slave port among MASTER_COUNT masters: master 0 has fixed priority, the rest are served round-robin.
// Latency: one cycle from a request to s_req; every completion is followed by one IDLE cycle.
// Backpressure: the grant stays locked until slave valid, master abort or watchdog timeout; other requesters wait.
module soc_membus_arbiter #(
    parameter int          MASTER_COUNT   = 3,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERROR_DATA     = 32'h0
) (
    input  logic                         clk,
    input  logic                         res,
    input  logic [MASTER_COUNT-1:0]      m_req,
    input  logic [32*MASTER_COUNT-1:0]   m_addr,
    input  logic [32*MASTER_COUNT-1:0]   m_write_data,
    input  logic [MASTER_COUNT-1:0]      m_write_en,
    input  logic [4*MASTER_COUNT-1:0]    m_byte_en,
    output logic [31:0]                  m_read_data,
    output logic [MASTER_COUNT-1:0]      m_valid,
    output logic [31:0]                  s_addr,
    output logic [31:0]                  s_write_data,
    output logic                         s_write_en,
    output logic [3:0]                   s_byte_en,
    output logic                         s_req,
    input  logic [31:0]                  s_read_data,
    input  logic                         s_valid,
    output logic [MASTER_COUNT-1:0]      grant,
    output logic                         timeout_err
);

    localparam int IW = $clog2(MASTER_COUNT);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [WW-1:0] WD_MAX  = '1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state;
    logic [IW-1:0]   g_idx;
    logic [IW-1:0]   rr_last;
    logic [WW-1:0]   wd_cnt;
    logic            win_vld;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand_idx;
    logic            wd_expired;

    assign wd_expired = (wd_cnt == WD_LAST);

    // Pick the next winner: master 0 outright, else the first low-priority requester after rr_last.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        cand_idx = '0;
        if (m_req[0]) begin
            win_vld = 1'b1;
        end else begin
            for (int k = 1; k < MASTER_COUNT; k++) begin
                // Rotate over 1..N-1 only; index 0 never takes part in the ring.
                cand_idx = IW'(((int'(rr_last) - 1 + k) % (MASTER_COUNT - 1)) + 1);
                if (!win_vld && m_req[cand_idx]) begin
                    win_vld = 1'b1;
                    win_idx = cand_idx;
                end
            end
        end
    end

    // Route the granted master to the slave and the slave response back; everything is quiet when idle.
    always_comb begin
        s_addr       = '0;
        s_write_data = '0;
        s_write_en   = 1'b0;
        s_byte_en    = '0;
        s_req        = 1'b0;
        m_read_data  = '0;
        m_valid      = '0;
        if (state == BUSY) begin
            s_addr       = m_addr[32*g_idx +: 32];
            s_write_data = m_write_data[32*g_idx +: 32];
            s_write_en   = m_write_en[g_idx];
            s_byte_en    = m_byte_en[4*g_idx +: 4];
            s_req        = m_req[g_idx];
            m_read_data  = s_read_data;
            if (s_valid) begin
                m_valid[g_idx] = 1'b1;
            end else if (m_req[g_idx] && wd_expired) begin
                // Watchdog completion: hand the master a defined error word instead of hanging it.
                m_valid[g_idx] = 1'b1;
                m_read_data    = ERROR_DATA;
            end
        end
    end

    // Arbitration FSM: grant on a win, hold until completion/abort/timeout, then one IDLE cycle.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state       <= IDLE;
            grant       <= '0;
            g_idx       <= '0;
            rr_last     <= IW'(MASTER_COUNT - 1);
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        state  <= BUSY;
                        grant  <= {{(MASTER_COUNT-1){1'b0}}, 1'b1} << win_idx;
                        g_idx  <= win_idx;
                        wd_cnt <= '0;
                        if (win_idx != '0) begin
                            rr_last <= win_idx;
                        end
                    end
                end
                BUSY: begin
                    if (s_valid || !m_req[g_idx]) begin
                        state <= IDLE;
                        grant <= '0;
                    end else if (wd_expired) begin
                        state       <= IDLE;
                        grant       <= '0;
                        timeout_err <= 1'b1;
                    end else if (wd_cnt != WD_MAX) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_membus_arbiter.sv
// Directed bench for soc_membus_arbiter with three masters and a 4-cycle watchdog.
// Inputs change 1 time unit after the rising edge; outputs are sampled 3 time units after it.
// Every expected value below is hand-derived from the intended arbitration behaviour.
module tb_soc_membus_arbiter;

    localparam int N = 3;

    logic              clk = 1'b0;
    logic              res;
    logic [N-1:0]      m_req;
    logic [32*N-1:0]   m_addr;
    logic [32*N-1:0]   m_write_data;
    logic [N-1:0]      m_write_en;
    logic [4*N-1:0]    m_byte_en;
    logic [31:0]       m_read_data;
    logic [N-1:0]      m_valid;
    logic [31:0]       s_addr;
    logic [31:0]       s_write_data;
    logic              s_write_en;
    logic [3:0]        s_byte_en;
    logic              s_req;
    logic [31:0]       s_read_data;
    logic              s_valid;
    logic [N-1:0]      grant;
    logic              timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] ADDR0 = 32'hA000_0000;
    localparam logic [31:0] ADDR1 = 32'hA000_0011;
    localparam logic [31:0] ADDR2 = 32'hA000_0022;

    soc_membus_arbiter #(
        .MASTER_COUNT   (N),
        .TIMEOUT_CYCLES (4),
        .ERROR_DATA     (32'h0)
    ) dut (
        .clk          (clk),
        .res          (res),
        .m_req        (m_req),
        .m_addr       (m_addr),
        .m_write_data (m_write_data),
        .m_write_en   (m_write_en),
        .m_byte_en    (m_byte_en),
        .m_read_data  (m_read_data),
        .m_valid      (m_valid),
        .s_addr       (s_addr),
        .s_write_data (s_write_data),
        .s_write_en   (s_write_en),
        .s_byte_en    (s_byte_en),
        .s_req        (s_req),
        .s_read_data  (s_read_data),
        .s_valid      (s_valid),
        .grant        (grant),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    logic [N-1:0] exp_g    [4];
    logic [31:0]  exp_addr [4];
    logic         exp_we   [4];
    logic [3:0]   exp_be   [4];

    initial begin
        exp_g[0] = 3'b010; exp_addr[0] = ADDR1; exp_we[0] = 1'b1; exp_be[0] = 4'b0011;
        exp_g[1] = 3'b100; exp_addr[1] = ADDR2; exp_we[1] = 1'b0; exp_be[1] = 4'b1111;
        exp_g[2] = 3'b010; exp_addr[2] = ADDR1; exp_we[2] = 1'b1; exp_be[2] = 4'b0011;
        exp_g[3] = 3'b100; exp_addr[3] = ADDR2; exp_we[3] = 1'b0; exp_be[3] = 4'b1111;

        res          = 1'b0;
        m_req        = '0;
        m_addr       = {ADDR2, ADDR1, ADDR0};
        m_write_data = {32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
        m_write_en   = 3'b011;
        m_byte_en    = {4'b1111, 4'b0011, 4'b1000};
        s_read_data  = '0;
        s_valid      = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_s_req", 32'(s_req), 32'h0);
        chk("rst_m_valid", 32'(m_valid), 32'h0);
        chk("rst_timeout_err", 32'(timeout_err), 32'h0);
        nxt();
        res = 1'b1;

        // Round-robin between masters 1 and 2 with a slave answering 2 cycles after s_req
        for (int i = 0; i < 4; i++) begin
            nxt(); m_req = 3'b110; s_valid = 1'b0; settle();
            chk("rr_idle_grant", 32'(grant), 32'h0);
            nxt(); settle();
            chk("rr_grant", 32'(grant), 32'(exp_g[i]));
            chk("rr_s_req", 32'(s_req), 32'h1);
            chk("rr_s_addr", s_addr, exp_addr[i]);
            chk("rr_s_we", 32'(s_write_en), 32'(exp_we[i]));
            chk("rr_s_be", 32'(s_byte_en), 32'(exp_be[i]));
            nxt(); settle();
            chk("rr_wait_m_valid", 32'(m_valid), 32'h0);
            nxt(); s_valid = 1'b1; s_read_data = 32'h5000_0000 + 32'(i); settle();
            chk("rr_m_valid", 32'(m_valid), 32'(exp_g[i]));
            chk("rr_rdata", m_read_data, 32'h5000_0000 + 32'(i));
        end
        // s_valid while idle must not reach the masters
        nxt(); m_req = 3'b000; s_valid = 1'b1; s_read_data = 32'h7777_7777; settle();
        chk("idle_grant", 32'(grant), 32'h0);
        chk("idle_m_valid", 32'(m_valid), 32'h0);
        chk("idle_rdata", m_read_data, 32'h0);

        // Master 0 waits for master 1 to finish, then beats pending master 2
        nxt(); s_valid = 1'b0; m_req = 3'b010; settle();
        nxt(); m_req = 3'b111; settle();
        chk("hp_g1", 32'(grant), 32'h2);
        nxt(); s_valid = 1'b1; s_read_data = 32'h3333_0001; settle();
        chk("hp_locked", 32'(grant), 32'h2);
        chk("hp_m1_valid", 32'(m_valid), 32'h2);
        nxt(); s_valid = 1'b0; m_req = 3'b101; settle();
        chk("hp_gap", 32'(grant), 32'h0);
        nxt(); s_valid = 1'b1; s_read_data = 32'h3333_0000; settle();
        chk("hp_g0", 32'(grant), 32'h1);
        chk("hp_s_addr0", s_addr, ADDR0);
        chk("hp_m0_valid", 32'(m_valid), 32'h1);
        nxt(); s_valid = 1'b0; m_req = 3'b100; settle();
        nxt(); s_valid = 1'b1; settle();
        chk("hp_g2", 32'(grant), 32'h4);
        nxt(); s_valid = 1'b0; m_req = 3'b000; settle();

        // Watchdog: slave never answers, forced completion on the 4th BUSY cycle
        nxt(); m_req = 3'b010; settle();
        for (int k = 1; k <= 3; k++) begin
            nxt(); s_read_data = 32'hDEAD_BEEF; settle();
            chk("wd_grant", 32'(grant), 32'h2);
            chk("wd_early_m_valid", 32'(m_valid), 32'h0);
            chk("wd_early_terr", 32'(timeout_err), 32'h0);
        end
        nxt(); settle();
        chk("wd_m_valid", 32'(m_valid), 32'h2);
        chk("wd_err_data", m_read_data, 32'h0);
        chk("wd_terr_same", 32'(timeout_err), 32'h0);
        nxt(); m_req = 3'b000; settle();
        chk("wd_terr_pulse", 32'(timeout_err), 32'h1);
        chk("wd_idle_grant", 32'(grant), 32'h0);
        nxt(); settle();
        chk("wd_terr_clear", 32'(timeout_err), 32'h0);

        // Master 2 aborts on its 2nd BUSY cycle
        nxt(); m_req = 3'b100; settle();
        nxt(); settle();
        chk("ab_grant", 32'(grant), 32'h4);
        chk("ab_s_req1", 32'(s_req), 32'h1);
        nxt(); m_req = 3'b000; settle();
        chk("ab_s_req0", 32'(s_req), 32'h0);
        chk("ab_m_valid", 32'(m_valid), 32'h0);
        nxt(); settle();
        chk("ab_grant_clr", 32'(grant), 32'h0);

        // Reset mid-BUSY drops outputs at once and restores master-1-first order
        nxt(); m_req = 3'b010; settle();
        nxt(); settle();
        chk("mr_grant", 32'(grant), 32'h2);
        nxt(); res = 1'b0; #1;
        chk("mr_grant_drop", 32'(grant), 32'h0);
        chk("mr_s_req_drop", 32'(s_req), 32'h0);
        nxt(); m_req = 3'b110;
        nxt(); res = 1'b1; settle();
        chk("mr_idle", 32'(grant), 32'h0);
        nxt(); settle();
        chk("mr_rr_restart", 32'(grant), 32'h2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
